// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the round-robin FIFO write arbiter.
// Holds the FSM state encoding and the index-width helper used by
// both the top level and the round-robin picker.
package fifo_arb_pkg;

  // FSM state encoding; busy is simply (state == ST_BURST).
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Width of an index into n items, never less than one bit.
  function automatic int idx_w(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Scans last+1, last+2, ... (mod N_REQ) and reports the first valid
// index. The wrap is explicit so non-power-of-two N_REQ works.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             any_o,
  output logic [IDX_W-1:0] next_o
);

  // Walk the candidates from farthest to nearest so the nearest valid
  // one (highest priority) is written last and wins.
  always_comb begin
    int cand;
    any_o  = 1'b0;
    next_o = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = int'(last_i) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (valid_i[cand]) begin
        any_o  = 1'b1;
        next_o = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among N_REQ
// producers. One producer owns the port for up to BURST_LEN beats;
// a single IDLE cycle separates consecutive grants.
//
// Handshake: a beat transfers on a rising edge when req_valid[i] and
// req_ready[i] are both high. req_ready is only offered to the current
// owner while the FIFO is not full, so fifo_we is never raised while
// fifo_full is set. Producers hold data stable while valid and not ready.
// The FSM state is visible on the busy output (high in BURST).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_we,
  output logic [DATA_W-1:0]       fifo_din,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(BURST_LEN - 1);

  logic [0:0]       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  // last_q doubles as the owner index while in BURST.
  logic [IDX_W-1:0] last_q, last_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_valid;
  logic             xfer;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .valid_i (req_valid),
    .last_i  (last_q),
    .any_o   (pick_any),
    .next_o  (pick_idx)
  );

  assign busy        = (state_q == ST_BURST);
  assign grant       = grant_q;
  assign owner_valid = req_valid[last_q];
  assign xfer        = busy & owner_valid & ~fifo_full;

  // Write port and per-requester accept, all combinational.
  always_comb begin
    int owner;
    owner     = int'(last_q);
    fifo_we   = xfer;
    req_ready = grant_q & {N_REQ{busy & ~fifo_full}};
    fifo_din  = '0;
    if (busy) fifo_din = req_data[owner*DATA_W +: DATA_W];
  end

  // Next-state logic: arbitrate in IDLE, count beats in BURST.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    last_d     = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d    = ST_BURST;
          grant_d    = '0;
          grant_d[pick_idx] = 1'b1;
          last_d     = pick_idx;
          beat_cnt_d = '0;
        end
      end
      ST_BURST: begin
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == CNT_FINAL) begin
            state_d    = ST_IDLE;
            grant_d    = '0;
            beat_cnt_d = '0;
          end
        end else if (!owner_valid) begin
          // Owner went away: end a partial burst. A full FIFO alone
          // never ends a burst; count and grant simply hold.
          state_d    = ST_IDLE;
          grant_d    = '0;
          beat_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        grant_d    = '0;
        beat_cnt_d = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      last_q     <= LAST_RST;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      last_q     <= last_d;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one synchronous FIFO write port (we, d_in, full) among N_REQ producers. Grants one producer at a time for a bounded burst and stalls on FIFO full. Drives the FIFO's we/d_in directly. The FIFO read side is untouched.

Parameters:
N_REQ, 4, number of requesters (>=2)
DATA_W, 8, data width, matching the FIFO d_in width
BURST_LEN, 4, maximum beats per grant (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-low
req_valid  input  N_REQ  per-requester data valid
req_data  input  N_REQ*DATA_W  flattened; requester i at [i*DATA_W +: DATA_W]
req_ready  output  N_REQ  per-requester accept; a beat transfers when valid&ready
fifo_full  input  1  FIFO full flag
fifo_we  output  1  FIFO write enable
fifo_din  output  DATA_W  FIFO write data
grant  output  N_REQ  one-hot registered current owner; 0 when idle
busy  output  1  high while in BURST

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, grant=0, beat_cnt=0, last=N_REQ-1, so requester 0 has highest priority first.
  - Consequently req_ready=0, fifo_we=0, busy=0.
  - Reset mid-burst aborts the burst; the in-flight beat is not written after the edge.
- State machine: IDLE, BURST (registered state).
  - IDLE: if any req_valid, choose the first valid index scanning last+1, last+2, ... (mod N_REQ).
  - On that edge: grant=onehot(idx), last=idx, beat_cnt=0, state=BURST. Otherwise stay IDLE.
  - BURST: xfer = req_valid[owner] & ~fifo_full.
  - On xfer, beat_cnt+1. If beat_cnt==BURST_LEN-1, go to IDLE and clear grant.
  - If req_valid[owner]==0 (no xfer this cycle), go to IDLE and clear grant; partial bursts are allowed.
  - fifo_full alone never ends a burst. beat_cnt and grant hold while full.
- Bubble rule: exactly one IDLE cycle between consecutive grants. Arbitration decisions use only IDLE-cycle req_valid.
- Combinational outputs, all in the same cycle:
  - req_ready[i] = busy & grant[i] & ~fifo_full
  - fifo_we = busy & req_valid[owner] & ~fifo_full
  - fifo_din = req_data slice of owner when busy, else 0
- No write ever occurs while fifo_full=1. The FIFO's own full guard is redundant but harmless.
- Latency: request in IDLE cycle t, grant visible at t+1, first beat written at the t+1/t+2 edge.
- Widths:
  - beat_cnt is $clog2(BURST_LEN+1) bits.
  - The owner index is $clog2(N_REQ) bits and wraps mod N_REQ. For non-power-of-2 N_REQ, wrap explicitly at N_REQ-1.
- Non-owner req_valid changes during BURST are ignored. Requesters must hold data stable while valid and not ready.

Decomposition:
- Shared package (fifo_arb_pkg):
  - state encoding localparams ST_IDLE=1'b0, ST_BURST=1'b1
  - index width helper (clog2, min 1)
- One sub-module, rr_pick: combinational; inputs valid[N_REQ] and last index; outputs any and next index. Instantiated once.
- Top holds the FSM, beat counter and muxes.

Test Plan:
1. Reset, then req_valid=4'b0001, data 0xA1,0xA2,... advancing on ready, fifo_full=0.
   -> grant=0001 the cycle after valid; 4 writes 0xA1..0xA4 on consecutive cycles; 1 idle cycle; regrant 0001; writes continue 0xA5...
2. req_valid=4'b1111, fifo_full=0.
   -> grant sequence 0001,0010,0100,1000,0001; each 4 beats; one busy=0 cycle between bursts; 16 writes per 20 cycles.
3. Owner 0 in BURST; fifo_full=1 after 2 beats for 3 cycles.
   -> fifo_we=0 and req_ready=0 for those 3 cycles; grant stays 0001; beats 3-4 written after full drops; then IDLE.
4. Owner 1 drops req_valid after 1 beat while requester 3 valid.
   -> next cycle IDLE with grant=0; following cycle grant=1000; requester 3 writes 4 beats.
5. After a grant to 3, only requesters 2 and 3 valid.
   -> scan 0,1,2 grants 2 (0100), then 3 next.
6. rst=0 during beat 2 of a burst by owner 2.
   -> after that edge grant=0, fifo_we=0, busy=0. On release with 4'b1111 valid, requester 0 is granted first.
